// File: rtl/bus_pkg.sv
// Shared types and constants for the bus demultiplexer slice.
package bus_pkg;

  localparam int unsigned N_TARGETS = 8;
  localparam int unsigned SEL_W     = 3;
  localparam logic [31:0] ERR_RDATA = 32'h0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } bus_state_t;

  function automatic logic [N_TARGETS-1:0] sel_onehot(input logic [SEL_W-1:0] sel);
    logic [N_TARGETS-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/bus_rsp_timer.sv
// BUSY-phase cycle counter; o_expired flags the last allowed cycle (limit 0 = never).
module bus_rsp_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic [CNT_W-1:0] i_limit,
  output logic             o_expired
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)        r_count <= '0;
    else if (i_clear) r_count <= '0;
    else if (i_en)    r_count <= r_count + 1'b1;
  end

  assign o_expired = (i_limit != '0) && (r_count == i_limit - 1'b1);

endmodule

// File: rtl/bus_demux.sv
// Routes one core request to one of eight address-decoded targets and
// returns a registered ack/rdata/err response.
module bus_demux
  import bus_pkg::*;
#(
  parameter int unsigned          SEL_MSB        = 31,
  parameter logic [N_TARGETS-1:0] TARGET_EN      = 8'hFF,
  parameter int unsigned          TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ini_rd,
  input  logic                    ini_wr,
  input  logic [31:0]             ini_addr,
  input  logic [31:0]             ini_wdata,
  output logic [31:0]             ini_rdata,
  output logic                    ini_ack,
  output logic                    ini_err,
  output logic                    busy,
  output logic [N_TARGETS-1:0]    tgt_rd,
  output logic [N_TARGETS-1:0]    tgt_wr,
  output logic [31:0]             tgt_addr,
  output logic [31:0]             tgt_wdata,
  input  logic [32*N_TARGETS-1:0] tgt_rdata,
  input  logic [N_TARGETS-1:0]    tgt_ack
);

  localparam int unsigned TMR_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

  bus_state_t           r_state, w_state;
  logic [SEL_W-1:0]     r_sel, w_sel;
  logic [N_TARGETS-1:0] r_tgt_rd, w_tgt_rd, r_tgt_wr, w_tgt_wr;
  logic [31:0]          r_addr, w_addr, r_wdata, w_wdata, r_rdata, w_rdata;
  logic                 r_ack, w_ack, r_err, w_err, r_busy, w_busy;

  logic [SEL_W-1:0]     w_sel_in;
  logic                 w_req_ok, w_req_err, w_expired, w_in_busy;
  logic [31:0]          w_slice;

  assign w_sel_in  = ini_addr[SEL_MSB -: SEL_W];
  assign w_req_ok  = (ini_rd ^ ini_wr) & TARGET_EN[w_sel_in];
  assign w_req_err = (ini_rd & ini_wr) | ((ini_rd ^ ini_wr) & ~TARGET_EN[w_sel_in]);
  assign w_slice   = tgt_rdata[{r_sel, 5'd0} +: 32];
  assign w_in_busy = (r_state == BUSY);

  bus_rsp_timer #(
    .CNT_W(TMR_W)
  ) u_timer (
    .i_clk    (clk),
    .i_rst    (reset),
    .i_clear  (~w_in_busy),
    .i_en     (w_in_busy),
    .i_limit  (TMR_W'(TIMEOUT_CYCLES)),
    .o_expired(w_expired)
  );

  // Next-state and next-output values; every output is registered below.
  always_comb begin
    w_state  = r_state;
    w_sel    = r_sel;
    w_tgt_rd = r_tgt_rd;
    w_tgt_wr = r_tgt_wr;
    w_addr   = r_addr;
    w_wdata  = r_wdata;
    w_rdata  = r_rdata;
    w_ack    = 1'b0;
    w_err    = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_req_ok) begin
          w_sel    = w_sel_in;
          w_addr   = ini_addr;
          w_wdata  = ini_wdata;
          w_tgt_rd = ini_rd ? sel_onehot(w_sel_in) : '0;
          w_tgt_wr = ini_wr ? sel_onehot(w_sel_in) : '0;
          w_state  = BUSY;
        end else if (w_req_err) begin
          w_ack   = 1'b1;
          w_err   = 1'b1;
          w_rdata = ERR_RDATA;
          w_state = RESP;
        end
      end
      BUSY: begin
        // Ack is tested first so it wins over a coincident timeout.
        if (tgt_ack[r_sel]) begin
          w_tgt_rd = '0;
          w_tgt_wr = '0;
          w_ack    = 1'b1;
          w_rdata  = (|r_tgt_wr) ? ERR_RDATA : w_slice;
          w_state  = RESP;
        end else if (w_expired) begin
          w_tgt_rd = '0;
          w_tgt_wr = '0;
          w_ack    = 1'b1;
          w_err    = 1'b1;
          w_rdata  = ERR_RDATA;
          w_state  = RESP;
        end
      end
      RESP:    w_state = IDLE;
      default: w_state = IDLE;
    endcase
    w_busy = (w_state != IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= IDLE;
      r_sel    <= '0;
      r_tgt_rd <= '0;
      r_tgt_wr <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_ack    <= 1'b0;
      r_err    <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_sel    <= w_sel;
      r_tgt_rd <= w_tgt_rd;
      r_tgt_wr <= w_tgt_wr;
      r_addr   <= w_addr;
      r_wdata  <= w_wdata;
      r_rdata  <= w_rdata;
      r_ack    <= w_ack;
      r_err    <= w_err;
      r_busy   <= w_busy;
    end
  end

  assign tgt_rd    = r_tgt_rd;
  assign tgt_wr    = r_tgt_wr;
  assign tgt_addr  = r_addr;
  assign tgt_wdata = r_wdata;
  assign ini_rdata = r_rdata;
  assign ini_ack   = r_ack;
  assign ini_err   = r_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_bus_demux.sv
// Transaction-level bench for bus_demux: two instances (all-mapped / slow timeout,
// and target 5 unmapped / 4-cycle timeout) driven by directed and random requests.
module tb_bus_demux;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         ini_rd    [2];
  logic         ini_wr    [2];
  logic [31:0]  ini_addr  [2];
  logic [31:0]  ini_wdata [2];
  logic [31:0]  ini_rdata [2];
  logic         ini_ack   [2];
  logic         ini_err   [2];
  logic         busy      [2];
  logic [7:0]   tgt_rd    [2];
  logic [7:0]   tgt_wr    [2];
  logic [31:0]  tgt_addr  [2];
  logic [31:0]  tgt_wdata [2];
  logic [255:0] tgt_rdata [2];
  logic [7:0]   tgt_ack   [2];

  bus_demux #(.SEL_MSB(31), .TARGET_EN(8'hFF), .TIMEOUT_CYCLES(255)) dut0 (
    .clk(clk), .reset(reset),
    .ini_rd(ini_rd[0]), .ini_wr(ini_wr[0]), .ini_addr(ini_addr[0]), .ini_wdata(ini_wdata[0]),
    .ini_rdata(ini_rdata[0]), .ini_ack(ini_ack[0]), .ini_err(ini_err[0]), .busy(busy[0]),
    .tgt_rd(tgt_rd[0]), .tgt_wr(tgt_wr[0]), .tgt_addr(tgt_addr[0]), .tgt_wdata(tgt_wdata[0]),
    .tgt_rdata(tgt_rdata[0]), .tgt_ack(tgt_ack[0])
  );

  bus_demux #(.SEL_MSB(31), .TARGET_EN(8'hDF), .TIMEOUT_CYCLES(4)) dut1 (
    .clk(clk), .reset(reset),
    .ini_rd(ini_rd[1]), .ini_wr(ini_wr[1]), .ini_addr(ini_addr[1]), .ini_wdata(ini_wdata[1]),
    .ini_rdata(ini_rdata[1]), .ini_ack(ini_ack[1]), .ini_err(ini_err[1]), .busy(busy[1]),
    .tgt_rd(tgt_rd[1]), .tgt_wr(tgt_wr[1]), .tgt_addr(tgt_addr[1]), .tgt_wdata(tgt_wdata[1]),
    .tgt_rdata(tgt_rdata[1]), .tgt_ack(tgt_ack[1])
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_idle_outputs(input int d, input string tag);
    check_eq({tag, ".rd"},   32'(tgt_rd[d]), 32'h0);
    check_eq({tag, ".wr"},   32'(tgt_wr[d]), 32'h0);
    check_eq({tag, ".ack"},  32'(ini_ack[d]), 32'h0);
    check_eq({tag, ".busy"}, 32'(busy[d]), 32'h0);
  endtask

  // One transaction on instance d. ack_wait < 0 means the target never acks.
  // spur: acks of other targets asserted throughout (must be ignored).
  task automatic run_txn(input int d, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] slice_val, input int ack_wait,
                         input logic [7:0] spur, input bit scramble);
    logic [7:0]   en;
    int           tmo, n;
    logic [2:0]   sel;
    logic [7:0]   oh;
    bit           is_err, tmo_hit;
    logic [255:0] bus;
    logic [31:0]  exp_rd;
    en  = (d == 0) ? 8'hFF : 8'hDF;
    tmo = (d == 0) ? 255 : 4;
    sel = addr[31:29];
    oh  = 8'h01 << sel;
    is_err = (rd && wr) || !en[sel];
    for (int j = 0; j < 8; j++) bus[j*32 +: 32] = $urandom;
    bus[sel*32 +: 32] = slice_val;

    @(negedge clk);
    ini_rd[d] = rd; ini_wr[d] = wr; ini_addr[d] = addr; ini_wdata[d] = wdata;
    tgt_rdata[d] = bus;
    tgt_ack[d] = spur & ~oh;
    @(posedge clk);

    if (is_err) begin
      @(negedge clk);
      check_eq("err.rd",    32'(tgt_rd[d]), 32'h0);
      check_eq("err.wr",    32'(tgt_wr[d]), 32'h0);
      check_eq("err.ack",   32'(ini_ack[d]), 32'h1);
      check_eq("err.err",   32'(ini_err[d]), 32'h1);
      check_eq("err.rdata", ini_rdata[d], 32'h0);
      check_eq("err.busy",  32'(busy[d]), 32'h1);
    end else begin
      if (ack_wait < 0 || (tmo != 0 && ack_wait + 1 > tmo)) begin
        n = tmo; tmo_hit = 1'b1;
      end else begin
        n = ack_wait + 1; tmo_hit = 1'b0;
      end
      exp_rd = (tmo_hit || wr) ? 32'h0 : slice_val;
      for (int k = 1; k <= n; k++) begin
        @(negedge clk);
        check_eq("strb.rd",    32'(tgt_rd[d]), 32'(rd ? oh : 8'h00));
        check_eq("strb.wr",    32'(tgt_wr[d]), 32'(wr ? oh : 8'h00));
        check_eq("strb.addr",  tgt_addr[d], addr);
        check_eq("strb.wdata", tgt_wdata[d], wdata);
        check_eq("strb.ack",   32'(ini_ack[d]), 32'h0);
        check_eq("strb.busy",  32'(busy[d]), 32'h1);
        if (scramble) begin
          ini_addr[d] = $urandom; ini_wdata[d] = $urandom;
        end
        tgt_ack[d] = (spur & ~oh) | ((k == ack_wait + 1) ? oh : 8'h00);
        @(posedge clk);
      end
      @(negedge clk);
      check_eq("rsp.rd",    32'(tgt_rd[d]), 32'h0);
      check_eq("rsp.wr",    32'(tgt_wr[d]), 32'h0);
      check_eq("rsp.ack",   32'(ini_ack[d]), 32'h1);
      check_eq("rsp.err",   32'(ini_err[d]), 32'(tmo_hit));
      check_eq("rsp.rdata", ini_rdata[d], exp_rd);
      check_eq("rsp.busy",  32'(busy[d]), 32'h1);
    end
    // Late ack from the selected target during RESP/IDLE must be ignored.
    ini_rd[d] = 1'b0; ini_wr[d] = 1'b0;
    tgt_ack[d] = spur | oh;
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs(d, "idle");
    tgt_ack[d] = 8'h00;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      ini_rd[d] = 1'b0; ini_wr[d] = 1'b0; ini_addr[d] = '0; ini_wdata[d] = '0;
      tgt_rdata[d] = '0; tgt_ack[d] = '0;
    end
    reset = 1'b1;
    #12;
    for (int d = 0; d < 2; d++) begin
      check_idle_outputs(d, "rst");
      check_eq("rst.err",   32'(ini_err[d]), 32'h0);
      check_eq("rst.rdata", ini_rdata[d], 32'h0);
      check_eq("rst.taddr", tgt_addr[d], 32'h0);
      check_eq("rst.twd",   tgt_wdata[d], 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;

    // Read target 2, target acks one cycle after the strobe.
    run_txn(0, 1'b1, 1'b0, 32'h4000_0010, 32'h0, 32'hCAFE_0002, 1, 8'h00, 1'b0);
    // Write target 7, five wait cycles.
    run_txn(0, 1'b0, 1'b1, 32'hE000_0000, 32'h1234_5678, 32'hDEAD_BEEF, 5, 8'h00, 1'b0);
    // Unmapped target 5.
    run_txn(1, 1'b1, 1'b0, 32'hA000_0000, 32'h0, 32'h5555_AAAA, 0, 8'h00, 1'b0);
    // Timeout after 4 strobe cycles, target never acks.
    run_txn(1, 1'b1, 1'b0, 32'h2000_0004, 32'h0, 32'h7777_0001, -1, 8'h00, 1'b0);
    // Ack and timeout on the same cycle: ack wins.
    run_txn(1, 1'b1, 1'b0, 32'h2000_0008, 32'h0, 32'h7777_0002, 3, 8'h00, 1'b0);
    // Spurious ack[3] while target 1 is selected.
    run_txn(0, 1'b1, 1'b0, 32'h2000_0000, 32'h0, 32'h0000_1111, 2, 8'h08, 1'b1);
    // Dual read+write request.
    run_txn(0, 1'b1, 1'b1, 32'h2000_0000, 32'h0, 32'h0, 0, 8'h08, 1'b0);

    // Reset during BUSY.
    @(negedge clk);
    ini_rd[0] = 1'b1; ini_addr[0] = 32'h6000_0000; tgt_ack[0] = 8'h00;
    @(posedge clk); @(negedge clk);
    check_eq("pre_rst.rd", 32'(tgt_rd[0]), 32'h08);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    check_idle_outputs(0, "mid_rst");
    ini_rd[0] = 1'b0;
    tgt_ack[0] = 8'h08;
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    check_idle_outputs(0, "post_rst");
    tgt_ack[0] = 8'h00;
    run_txn(0, 1'b1, 1'b0, 32'h6000_0020, 32'h0, 32'hBEEF_0003, 0, 8'h00, 1'b0);

    // Random transactions on both instances.
    for (int i = 0; i < 40; i++) begin
      int d, mode, wt;
      logic r, w;
      d    = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 9));
      r    = (mode == 0) || (mode <= 5);
      w    = (mode == 0) || (mode > 5);
      wt   = int'($urandom_range(0, 6));
      if (d == 1 && wt == 6) wt = -1;
      run_txn(d, r, w, $urandom, $urandom, $urandom, wt, 8'($urandom), 1'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
